// File: rtl/fre_ramp_pkg.sv
// rtl/fre_ramp_pkg.sv - shared state encoding and default sizing for the frequency-slew generator
package fre_ramp_pkg;

  localparam int W_DEF   = 20;
  localparam int CH_DEF  = 2;
  localparam int DIV_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ch_state_t;

endpackage

// File: rtl/fre_ramp_ch.sv
// rtl/fre_ramp_ch.sv - one slew channel: target/step registers, idle/ramp FSM, clamped step datapath
module fre_ramp_ch
  import fre_ramp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] need,
  input  logic [W-1:0] gap,
  output logic [W-1:0] out,
  output logic         busy,
  output logic         done
);

  ch_state_t    state;
  logic [W-1:0] cur;
  logic [W-1:0] tgt;
  logic [W-1:0] stp;
  logic         up;
  logic [W-1:0] diff;
  logic [W-1:0] nxt;

  // Distance is always larger-minus-smaller, so a step that would reach or
  // pass the target clamps onto it instead of overshooting or wrapping.
  always_comb begin
    up   = cur < tgt;
    diff = up ? (tgt - cur) : (cur - tgt);
    nxt  = tgt;
    if (stp != '0 && diff > stp) begin
      nxt = up ? (cur + stp) : (cur - stp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur   <= '0;
      tgt   <= '0;
      stp   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        tgt <= need;
        stp <= gap;
        if (need == cur) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= ST_RAMP;
          busy  <= 1'b1;
        end
      end else if (state == ST_RAMP && tick) begin
        cur <= nxt;
        if (nxt == tgt) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign out = cur;

endmodule

// File: rtl/fre_ramp.sv
// rtl/fre_ramp.sv - multi-channel frequency-slew generator with a shared update prescaler
module fre_ramp
  import fre_ramp_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int CH  = CH_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CH*W-1:0] fre_need,
  input  logic [CH*W-1:0] fre_gap,
  input  logic [CH-1:0]   fre_load,
  output logic [CH*W-1:0] fre_out,
  output logic [CH-1:0]   fre_busy,
  output logic [CH-1:0]   fre_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CNT_MAX);

  // Dropping en restarts the phase, so a resumed ramp waits a full DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    fre_ramp_ch #(
      .W(W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .load (fre_load[g]),
      .need (fre_need[g*W +: W]),
      .gap  (fre_gap[g*W +: W]),
      .out  (fre_out[g*W +: W]),
      .busy (fre_busy[g]),
      .done (fre_done[g])
    );
  end

endmodule

// File: tb/tb_fre_ramp.sv
// tb/tb_fre_ramp.sv - scoreboard bench for fre_ramp with directed and randomized loads
module tb_fre_ramp;

  localparam int W   = 20;
  localparam int CH  = 2;
  localparam int DIV = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [CH*W-1:0] fre_need = '0;
  logic [CH*W-1:0] fre_gap = '0;
  logic [CH-1:0]   fre_load = '0;
  logic [CH*W-1:0] fre_out;
  logic [CH-1:0]   fre_busy;
  logic [CH-1:0]   fre_done;

  always #5 clk = ~clk;

  fre_ramp #(.W(W), .CH(CH), .DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .fre_need(fre_need),
    .fre_gap (fre_gap),
    .fre_load(fre_load),
    .fre_out (fre_out),
    .fre_busy(fre_busy),
    .fre_done(fre_done)
  );

  int tests = 0;
  int fails = 0;

  // Expected output values still to appear, per channel.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] mcur[CH];
  logic [W-1:0] prev[CH];
  logic         pend_done[CH];
  int           k = 0;
  logic         tick_edge = 1'b0;
  logic [CH-1:0] ld_edge = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsz(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int c, input logic [W-1:0] v);
    if (c == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qclr(input int c);
    if (c == 0) q0.delete(); else q1.delete();
  endtask

  task automatic qpop(input int c, output logic [W-1:0] v);
    if (c == 0) v = q0.pop_front(); else v = q1.pop_front();
  endtask

  // Ramp = ceil(distance/gap) ticks; every tick but the last moves a full gap.
  task automatic build(input int c, input longint from, input longint need, input longint gap);
    longint d, n, sgn;
    d   = (need > from) ? need - from : from - need;
    sgn = (need > from) ? 1 : -1;
    n   = (gap == 0) ? 1 : (d + gap - 1) / gap;
    for (longint i = 1; i < n; i++) qpush(c, W'(from + sgn * i * gap));
    qpush(c, W'(need));
  endtask

  // Independent view of the prescaler: the DIV-th consecutive enabled edge updates.
  always @(posedge clk) begin
    ld_edge = fre_load;
    if (!rst_n || !en) begin
      k = 0;
      tick_edge = 1'b0;
    end else if (k == DIV - 1) begin
      k = 0;
      tick_edge = 1'b1;
    end else begin
      k++;
      tick_edge = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) prev[c] = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        logic [W-1:0] v, e;
        logic changed, exp_change, popped, exp_done;
        v = fre_out[c*W +: W];
        changed = (v != prev[c]);
        exp_change = tick_edge && !ld_edge[c] && (qsz(c) > 0);
        popped = 1'b0;
        if (changed || exp_change) chk($sformatf("step_timing ch%0d", c), changed, exp_change);
        if (changed) begin
          if (qsz(c) == 0) begin
            chk($sformatf("unexpected_out ch%0d", c), v, prev[c]);
          end else begin
            qpop(c, e);
            popped = 1'b1;
            chk($sformatf("out_value ch%0d", c), v, e);
            mcur[c] = e;
          end
        end
        prev[c] = v;
        exp_done = (popped && qsz(c) == 0) || pend_done[c];
        pend_done[c] = 1'b0;
        if (exp_done || fre_done[c]) chk($sformatf("done ch%0d", c), fre_done[c], exp_done);
        chk($sformatf("busy ch%0d", c), fre_busy[c], qsz(c) > 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int c, input int need, input int gap);
    fre_need[c*W +: W] = W'(need);
    fre_gap[c*W +: W]  = W'(gap);
    fre_load[c] = 1'b1;
    qclr(c);
    if (W'(need) == mcur[c]) pend_done[c] = 1'b1;
    else build(c, mcur[c], need, gap);
    step();
    fre_load[c] = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((qsz(0) > 0 || qsz(1) > 0 || pend_done[0] || pend_done[1]) && n < budget) begin
      step();
      n++;
    end
    step();
    if (n >= budget) chk({name, " timeout"}, n, 0);
  endtask

  task automatic wait_cur(input int c, input int val, input int budget);
    int n;
    n = 0;
    while (mcur[c] != W'(val) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("wait_cur timeout", mcur[c], val);
  endtask

  task automatic reset_model();
    for (int c = 0; c < CH; c++) begin
      qclr(c);
      mcur[c] = '0;
      pend_done[c] = 1'b0;
    end
  endtask

  initial begin
    int n, c, need, gap, pick;
    reset_model();
    #2;
    chk("reset fre_out", fre_out, 0);
    chk("reset fre_busy", fre_busy, 0);
    chk("reset fre_done", fre_done, 0);
    step();
    step();
    rst_n = 1'b1;
    en = 1'b1;

    load(0, 1600, 10);
    wait_idle("rise", 2000);
    load(0, 800, 10);
    wait_idle("fall", 1000);
    load(0, 0, 0);
    wait_idle("to_zero", 100);
    load(0, 25, 10);
    wait_idle("nonmult_up", 100);
    load(0, 0, 10);
    wait_idle("nonmult_down", 100);
    load(0, 500, 0);
    wait_idle("instant", 100);
    load(0, 500, 7);
    wait_idle("equal", 100);

    // Line the load up with the edge that carries a tick.
    n = 0;
    while (k != DIV - 1 && n < 20) begin
      step();
      n++;
    end
    load(0, 1000, 10);
    wait_idle("coincident", 1000);

    load(0, 0, 0);
    wait_idle("clear", 100);
    load(1, 5000, 7);
    load(0, 1000, 50);
    wait_cur(0, 300, 200);
    load(0, 100, 50);
    repeat (5) step();
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    wait_idle("retarget", 4000);

    load(1, 3000, 5);
    load(0, 2000, 13);
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    chk("midramp reset fre_out", fre_out, 0);
    chk("midramp reset fre_busy", fre_busy, 0);
    chk("midramp reset fre_done", fre_done, 0);
    reset_model();
    repeat (3) step();
    rst_n = 1'b1;
    load(0, 200, 30);
    wait_idle("after_reset", 200);

    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, CH - 1);
      pick = $urandom_range(0, 9);
      need = (pick == 1) ? int'(mcur[c]) : $urandom_range(0, 3000);
      gap = (pick == 0) ? 0 : $urandom_range(20, 400);
      load(c, need, gap);
      if ($urandom_range(0, 5) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 10)) step();
        en = 1'b1;
      end
      repeat ($urandom_range(0, 40)) step();
    end
    wait_idle("random", 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
